st_irq_ctrl: RTL

//  Interrupt arbiter/IACK sequencer between the 68000 and its three ST sources: HBL (autovector lvl 2),
//  VBL (autovector lvl 4), MFP (vectored lvl MFP_LEVEL). Encodes highest pending source onto IPL.

---
 rtl/st_irq_ctrl_if.sv | 23 ++
 rtl/st_irq_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/st_irq_ctrl_if.sv
// CPU/MFP side of the ST interrupt glue: IACK bus decode in, IPL and acknowledge strobes out.
// The controller uses the slave modport; the CPU/board side (or a bench) uses master.
interface st_irq_ctrl_if;
    logic       cpu_as_n;
    logic       cpu_iack;
    logic [2:0] cpu_ack_lvl;
    logic       mfp_irq;
    logic [2:0] ipl_n;
    logic       mfp_iack;
    logic       cpu_dtack;
    logic       cpu_vpa;
    logic       cpu_berr;

    modport slave (
        input  cpu_as_n, cpu_iack, cpu_ack_lvl, mfp_irq,
        output ipl_n, mfp_iack, cpu_dtack, cpu_vpa, cpu_berr
    );

    modport master (
        output cpu_as_n, cpu_iack, cpu_ack_lvl, mfp_irq,
        input  ipl_n, mfp_iack, cpu_dtack, cpu_vpa, cpu_berr
    );
endinterface

// File: rtl/st_irq_ctrl.sv
// ST interrupt arbiter: prioritises HBL/VBL/MFP onto the 68000 IPL lines and sequences
// interrupt-acknowledge cycles as MFP vectored, autovectored (VPA) or spurious (BERR).
module st_irq_ctrl #(
    parameter int MFP_LEVEL     = 6,
    parameter int MFP_ACK_TICKS = 3,
    parameter int SPUR_TICKS    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_en,
    input  logic               hbl_in,
    input  logic               vbl_in,
    output logic               busy,
    st_irq_ctrl_if.slave       bus
);

    localparam logic [2:0] MFP_LVL = 3'(MFP_LEVEL);
    localparam logic [3:0] MFP_TC  = 4'(MFP_ACK_TICKS);
    localparam logic [3:0] SPUR_TC = 4'(SPUR_TICKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MFP,
        S_AUTO,
        S_SPUR,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       hbl_q, vbl_q;
    logic       hbl_pend_q, hbl_pend_d;
    logic       vbl_pend_q, vbl_pend_d;
    logic       hbl_clr, vbl_clr;
    logic [2:0] ipl_n_q, ipl_n_d;
    logic       mfp_iack_q, mfp_iack_d;
    logic       dtack_q, dtack_d;
    logic       vpa_q, vpa_d;
    logic       berr_q, berr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            hbl_q      <= hbl_in;
            vbl_q      <= vbl_in;
            hbl_pend_q <= 1'b0;
            vbl_pend_q <= 1'b0;
            ipl_n_q    <= 3'b111;
            mfp_iack_q <= 1'b0;
            dtack_q    <= 1'b0;
            vpa_q      <= 1'b0;
            berr_q     <= 1'b0;
        end else if (clk_en) begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hbl_q      <= hbl_in;
            vbl_q      <= vbl_in;
            hbl_pend_q <= hbl_pend_d;
            vbl_pend_q <= vbl_pend_d;
            ipl_n_q    <= ipl_n_d;
            mfp_iack_q <= mfp_iack_d;
            dtack_q    <= dtack_d;
            vpa_q      <= vpa_d;
            berr_q     <= berr_d;
        end
    end

    // A fresh edge in the same tick as an acknowledge clear keeps the request pending.
    always_comb begin
        hbl_pend_d = (hbl_in & ~hbl_q) | (hbl_pend_q & ~hbl_clr);
        vbl_pend_d = (vbl_in & ~vbl_q) | (vbl_pend_q & ~vbl_clr);
        if (bus.mfp_irq)
            ipl_n_d = ~MFP_LVL;
        else if (vbl_pend_q)
            ipl_n_d = ~3'd4;
        else if (hbl_pend_q)
            ipl_n_d = ~3'd2;
        else
            ipl_n_d = 3'b111;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mfp_iack_d = mfp_iack_q;
        dtack_d    = dtack_q;
        vpa_d      = vpa_q;
        berr_d     = berr_q;
        hbl_clr    = 1'b0;
        vbl_clr    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.cpu_iack && !bus.cpu_as_n) begin
                    if (bus.cpu_ack_lvl == MFP_LVL && bus.mfp_irq) begin
                        state_d    = S_MFP;
                        cnt_d      = 4'd1;
                        mfp_iack_d = 1'b1;
                    end else if (bus.cpu_ack_lvl == 3'd4 && vbl_pend_q) begin
                        state_d = S_AUTO;
                        vpa_d   = 1'b1;
                        vbl_clr = 1'b1;
                    end else if (bus.cpu_ack_lvl == 3'd2 && hbl_pend_q) begin
                        state_d = S_AUTO;
                        vpa_d   = 1'b1;
                        hbl_clr = 1'b1;
                    end else begin
                        state_d = S_SPUR;
                        cnt_d   = 4'd1;
                    end
                end
            end
            S_MFP: begin
                if (cnt_q >= MFP_TC) begin
                    state_d = S_DONE;
                    dtack_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_AUTO: begin
                state_d = S_DONE;
            end
            S_SPUR: begin
                if (cnt_q >= SPUR_TC) begin
                    state_d = S_DONE;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Address strobe released: normal end in DONE, abort anywhere earlier.
        if (state_q != S_IDLE && bus.cpu_as_n) begin
            state_d    = S_IDLE;
            mfp_iack_d = 1'b0;
            dtack_d    = 1'b0;
            vpa_d      = 1'b0;
            berr_d     = 1'b0;
        end
    end

    assign bus.ipl_n     = ipl_n_q;
    assign bus.mfp_iack  = mfp_iack_q;
    assign bus.cpu_dtack = dtack_q;
    assign bus.cpu_vpa   = vpa_q;
    assign bus.cpu_berr  = berr_q;
    assign busy          = (state_q != S_IDLE);

endmodule
